// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle between the FIFO write controller and the producer/memory/read domain.
interface fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  winc;
  logic                  clr_ovf;
  logic [ADDR_WIDTH:0]   rptr_gray_async;
  logic                  wclkEn;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  overflow;

  modport master (
    output winc, clr_ovf, rptr_gray_async,
    input  wclkEn, waddr, wptr_gray, full, almost_full, wlevel, overflow
  );

  modport slave (
    input  winc, clr_ovf, rptr_gray_async,
    output wclkEn, waddr, wptr_gray, full, almost_full, wlevel, overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side controller: write enable/address, binary and Gray write
// pointers, read-pointer synchroniser, and full/almost-full/level/overflow status.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic           CLK,
  input  logic           RST,
  fifo_wr_ctrl_if.slave  wr
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AF_T = PW'(AFULL_THRESH);

  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] wgray;
  logic [ADDR_WIDTH:0] rq1;
  logic [ADDR_WIDTH:0] rq2;
  logic [ADDR_WIDTH:0] rbin_sync;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wgray_next;
  logic [ADDR_WIDTH:0] full_cmp;
  logic [ADDR_WIDTH:0] level;
  logic                full_q;
  logic                ovf_q;
  logic                wen;

  // A write is dropped while full or in reset; the memory captures on the same edge.
  assign wen        = wr.winc & ~full_q & ~RST;
  assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wen};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Full when the write pointer is exactly one lap ahead: in Gray code that
  // means the top two bits differ and the rest match.
  assign full_cmp = {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]};

  // Gray-to-binary of the synchronised read pointer: bit i is the XOR of all bits at or above i.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      rbin_sync[i] = ^(rq2 >> i);
    end
  end

  // Level lags real reads by the synchroniser, so it can only over-report occupancy.
  assign level = wbin - rbin_sync;

  assign wr.wclkEn      = wen;
  assign wr.waddr       = RST ? '0 : wbin[ADDR_WIDTH-1:0];
  assign wr.wptr_gray   = wgray;
  assign wr.full        = full_q;
  assign wr.wlevel      = RST ? '0 : level;
  assign wr.almost_full = RST ? 1'b0 : (level >= AF_T);
  assign wr.overflow    = ovf_q;

  // Two-flop synchroniser for the read pointer coming from the other clock domain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= wr.rptr_gray_async;
      rq2 <= rq1;
    end
  end

  // Write pointers advance together; full is evaluated against the post-increment pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wbin   <= '0;
      wgray  <= '0;
      full_q <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      wgray  <= wgray_next;
      full_q <= (wgray_next == full_cmp);
    end
  end

  // Sticky overflow; a write attempt while full outranks a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else if (wr.winc & full_q) begin
      ovf_q <= 1'b1;
    end else if (wr.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

endmodule
